// File: rtl/fetch_ctrl.sv
// Instruction-fetch/sequencing controller sitting in front of the program counter.
// It fetches from instruction memory, waits MEM_LAT cycles, captures the instruction,
// resolves JMP/BZ/BNZ/HALT locally and hands every other opcode to the execute stage.
// The opcode field sits in ir[15:12], so INSTR_W must be at least 16.
module fetch_ctrl #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         pc_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               zero_flag,
    input  logic               exec_ready,
    output logic               imem_rd,
    output logic               pc_enable,
    output logic               pc_ld,
    output logic [7:0]         pc_target,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_valid,
    output logic               halted
);

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDecode,
        StExec,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAlu9 = 4'h9;
    localparam logic [3:0] OpJmp  = 4'hA;
    localparam logic [3:0] OpBz   = 4'hB;
    localparam logic [3:0] OpBnz  = 4'hC;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [2:0] LatCnt = 3'(MEM_LAT);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [7:0]           fetch_pc_q, fetch_pc_d;
    logic [2:0]           cnt_q, cnt_d;

    logic [3:0]           op;
    logic [7:0]           operand;
    logic                 taken;

    assign op      = ir_q[15:12];
    assign operand = ir_q[7:0];
    assign ir      = ir_q;

    // Branch condition for the instruction currently held in ir.
    always_comb begin
        taken = 1'b0;
        if (op == OpBz) begin
            taken = zero_flag;
        end else if (op == OpBnz) begin
            taken = ~zero_flag;
        end
    end

    // State, instruction register, fetch address and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            ir_q       <= '0;
            fetch_pc_q <= 8'h00;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and strobes; strobes are forced low while reset is held so that
    // the FETCH reset state does not leak a read strobe.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        imem_rd    = 1'b0;
        pc_enable  = 1'b0;
        pc_ld      = 1'b0;
        pc_target  = 8'h00;
        exec_valid = 1'b0;
        halted     = 1'b0;

        if (reset) begin
            unique case (state_q)
                StFetch: begin
                    imem_rd    = 1'b1;
                    fetch_pc_d = pc_addr;
                    cnt_d      = 3'd1;
                    state_d    = StWait;
                end
                StWait: begin
                    if (cnt_q >= LatCnt) begin
                        // Capture and PC increment share one edge.
                        ir_d      = imem_data;
                        pc_enable = 1'b1;
                        state_d   = StDecode;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StDecode: begin
                    state_d = StFetch;
                    if (op == OpJmp) begin
                        pc_enable = 1'b1;
                        pc_ld     = 1'b1;
                        pc_target = operand;
                    end else if (taken) begin
                        // Offset is relative to the branch's own address, wraps mod 256.
                        pc_enable = 1'b1;
                        pc_ld     = 1'b1;
                        pc_target = fetch_pc_q + operand;
                    end else if (op == OpHalt) begin
                        state_d = StHalt;
                    end else if (op != OpNop && op <= OpAlu9) begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    exec_valid = 1'b1;
                    if (exec_ready) begin
                        state_d = StFetch;
                    end
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch/sequencing controller directly upstream of the program counter. It drives the PC's enable, load and load-address inputs.
- Reads the PC address, issues a synchronous instruction-memory read and waits a fixed latency. It then captures the instruction, advances the PC and resolves JMP/BZ/BNZ/HALT locally.
- Hands all other opcodes to the execute stage over a valid/ready handshake.

Parameters:
- MEM_LAT, 1, instruction-memory read latency in cycles (legal range 1..4); data is valid MEM_LAT cycles after the FETCH cycle.
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_addr  in  8  current PC value, the address of the instruction being fetched.
- imem_data  in  INSTR_W  instruction-memory read data.
- zero_flag  in  1  ALU zero flag, sampled in DECODE.
- exec_ready  in  1  execute stage accepts the instruction.
- imem_rd  out  1  memory read strobe.
- pc_enable  out  1  to PC enable.
- pc_ld  out  1  to PC ld_pc.
- pc_target  out  8  to PC addr_ld; meaningful only when pc_ld=1.
- ir  out  INSTR_W  instruction register.
- exec_valid  out  1  instruction in ir offered to the execute stage.
- halted  out  1  HALT executed.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=FETCH; ir=0; fetch_pc=0; cnt=0.
  - All outputs 0.
  - Reset mid-operation abandons any pending fetch or handshake. The first FETCH after release reads address 0, since the PC also resets.
- Instruction fields:
  - op=ir[15:12], operand=ir[7:0].
  - 0x0 NOP; 0x1-0x9 ALU ops (go to EXEC); 0xA JMP absolute; 0xB BZ; 0xC BNZ; 0xD/0xE reserved, executed as NOP; 0xF HALT.
- States: FETCH, WAIT, DECODE, EXEC, HALT.
- FETCH (1 cycle):
  - imem_rd=1; fetch_pc<=pc_addr; cnt<=1; next WAIT.
- WAIT:
  - While cnt<MEM_LAT: cnt<=cnt+1.
  - When cnt==MEM_LAT: ir<=imem_data; pc_enable=1, pc_ld=0 for this cycle only, so the PC increments on the same edge; next DECODE.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle.
- DECODE (1 cycle, combinational Mealy outputs from ir):
  - JMP: pc_enable=1, pc_ld=1, pc_target=operand; next FETCH.
  - BZ and zero_flag=1, or BNZ and zero_flag=0 (taken): pc_enable=1, pc_ld=1, pc_target=fetch_pc+signed(operand), wrapping mod 256. The offset is relative to the branch's own address. Next FETCH.
  - Branch not taken, NOP or reserved: no PC action; next FETCH.
  - ALU op: next EXEC.
  - HALT: next HALT.
- EXEC:
  - exec_valid=1 and ir held stable until a cycle with exec_ready=1. Transfer completes on that edge; next FETCH.
  - exec_valid drops the following cycle.
  - exec_ready outside EXEC is ignored.
- HALT:
  - halted=1; all other strobes 0. Terminal state until reset.
- Timing rules:
  - pc_enable is never asserted in FETCH, EXEC or HALT.
  - At most one PC update per state-visit.
  - Cycles per instruction: 2+MEM_LAT for NOP/branch/jump; 2+MEM_LAT+k for ALU ops, where k≥1 is the number of EXEC cycles.
- Wrap-around:
  - fetch_pc=0x02 with offset 0xFC gives target 0xFE.
  - fetch_pc=0xFF with offset 0x01 gives target 0x00.
  - Sequential fetch past 0xFF wraps via the PC's own increment.
- zero_flag is sampled only in DECODE; changes elsewhere have no effect.

Test Plan:
- Reset, then hold reset=1, MEM_LAT=1, memory all NOP: imem_rd pulses every 3 cycles; pc_enable pulses once per instruction; PC reads 0,1,2,...; halted=0.
- addr 0 = JMP 0x40 (0xA040): in DECODE pc_ld=1, pc_target=0x40; next FETCH sees pc_addr=0x40.
- BZ at 0x10, offset 0xF8: zero_flag=1 gives target 0x08; zero_flag=0 gives no pc_ld and next fetch at 0x11. Same check for BNZ with flag polarity inverted.
- ALU op 0x1234 with exec_ready held low for 3 cycles, then high: exec_valid=1 for 4 cycles with ir=0x1234 stable, then returns to FETCH.
- MEM_LAT=3: imem_rd to ir capture is exactly 3 cycles; ir is loaded on the same edge as the PC increment; no early capture.
- HALT (0xF000): halted=1 and stays; no imem_rd or pc_enable afterwards. Asserting reset mid-EXEC (exec_valid=1) immediately clears all outputs, and fetch restarts at 0.
